// File: rtl/dff_pipe_pkg.sv
// Shared helpers for the dff_pipe register pipeline.
// Sizes the occupancy counter so it can hold every value from 0 to DEPTH.
package dff_pipe_pkg;

    function automatic int unsigned occ_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One register stage of dff_pipe: a valid bit plus a data register.
// The data register loads only on a real, unflushed transfer, so bubbles never overwrite it.
module dff_pipe_stage #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_adv,
    output logic             v,
    output logic [WIDTH-1:0] d,
    output logic             adv
);

    logic             v_d;
    logic [WIDTH-1:0] d_d;
    logic             load;

    // dn_adv means the next stage (or the consumer) can take this word now.
    assign adv  = v & dn_adv;
    assign load = up_valid & ~flush;

    always_comb begin
        v_d = v;
        if (flush) begin
            v_d = 1'b0;
        end else if (up_valid) begin
            v_d = 1'b1;
        end else if (adv) begin
            v_d = 1'b0;
        end
    end

    always_comb begin
        d_d = d;
        if (load) begin
            d_d = up_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v <= 1'b0;
            d <= RESET_VAL;
        end else begin
            v <= v_d;
            d <= d_d;
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage, WIDTH-bit register pipeline with valid/ready at both ends.
// Stages stall independently and empty stages collapse under backpressure.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic [WIDTH-1:0]         din,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [WIDTH-1:0]         dout,
    output logic [occ_w(DEPTH)-1:0]  occupancy
);

    localparam int unsigned OCC_W = occ_w(DEPTH);

    if (DEPTH == 0) begin : g_depth_check
        $error("dff_pipe: DEPTH must be at least 1");
    end
    if (WIDTH == 0) begin : g_width_check
        $error("dff_pipe: WIDTH must be at least 1");
    end

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] room;
    logic [DEPTH-1:0] up_valid;
    logic [WIDTH-1:0] d       [DEPTH];
    logic [WIDTH-1:0] up_data [DEPTH];

    logic             in_xfer;
    logic             out_xfer;
    logic [OCC_W-1:0] occ_d;
    logic [OCC_W-1:0] occ_q;

    // room[i]: whatever sits downstream of stage i can absorb a word this cycle.
    // Derived from v alone so the ready chain never loops through the stage instances.
    always_comb begin
        room            = '0;
        room[DEPTH-1]   = dout_ready;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            room[i] = ~v[i + 1] | room[i + 1];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign up_valid[i] = in_xfer;
            assign up_data[i]  = din;
        end else begin : g_body
            assign up_valid[i] = adv[i - 1];
            assign up_data[i]  = d[i - 1];
        end

        dff_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .up_valid (up_valid[i]),
            .up_data  (up_data[i]),
            .dn_adv   (room[i]),
            .v        (v[i]),
            .d        (d[i]),
            .adv      (adv[i])
        );
    end

    assign din_ready  = ~v[0] | adv[0];
    assign in_xfer    = din_valid & din_ready;
    assign out_xfer   = adv[DEPTH - 1];
    assign dout_valid = v[DEPTH - 1];
    assign dout       = d[DEPTH - 1];

    // Internal moves keep the count; only the two ends change it.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (in_xfer && !out_xfer) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!in_xfer && out_xfer) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: a 4x8 instance and a 1x16 instance checked every cycle against
// word-list models, plus directed scenarios with hand-computed expectations.
module tb_dff_pipe;
    import dff_pipe_pkg::*;

    localparam int          D     = 4;
    localparam logic [7:0]  A_RST = 8'h3C;
    localparam logic [15:0] B_RST = 16'hA5A5;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    logic                   a_flush = 1'b0, a_din_valid = 1'b0, a_dout_ready = 1'b0;
    logic [7:0]             a_din = '0;
    logic                   a_din_ready, a_dout_valid;
    logic [7:0]             a_dout;
    logic [occ_w(D)-1:0]    a_occupancy;

    logic                   b_flush = 1'b0, b_din_valid = 1'b0, b_dout_ready = 1'b0;
    logic [15:0]            b_din = '0;
    logic                   b_din_ready, b_dout_valid;
    logic [15:0]            b_dout;
    logic [occ_w(1)-1:0]    b_occupancy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dff_pipe #(.WIDTH(8), .DEPTH(D), .RESET_VAL(A_RST)) u_dut_a (
        .clk(clk), .reset(reset), .flush(a_flush),
        .din_valid(a_din_valid), .din_ready(a_din_ready), .din(a_din),
        .dout_valid(a_dout_valid), .dout_ready(a_dout_ready), .dout(a_dout),
        .occupancy(a_occupancy)
    );

    dff_pipe #(.WIDTH(16), .DEPTH(1), .RESET_VAL(B_RST)) u_dut_b (
        .clk(clk), .reset(reset), .flush(b_flush),
        .din_valid(b_din_valid), .din_ready(b_din_ready), .din(b_din),
        .dout_valid(b_dout_valid), .dout_ready(b_dout_ready), .dout(b_dout),
        .occupancy(b_occupancy)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at time %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model A: words in arrival order (oldest first), each with its stage position.
    typedef bit bitq_t[$];
    int          ma_pos[$];
    logic [7:0]  ma_data[$];
    logic [7:0]  ma_last = A_RST;
    logic [15:0] mb_q[$];
    logic [15:0] mb_last = B_RST;

    // A word moves on if the slot ahead is empty or the word ahead moves too.
    function automatic bitq_t ma_adv(input logic dr);
        bitq_t a;
        for (int k = 0; k < ma_pos.size(); k++) begin
            if (k == 0) a.push_back((ma_pos[0] == D - 1) ? dr : 1'b1);
            else a.push_back((ma_pos[k] + 1 != ma_pos[k - 1]) || a[k - 1]);
        end
        return a;
    endfunction

    function automatic logic ma_ready(input logic dr);
        bitq_t a;
        int    n;
        a = ma_adv(dr);
        n = ma_pos.size();
        if (n == 0) return 1'b1;
        return (ma_pos[n - 1] != 0) || a[n - 1];
    endfunction

    function automatic logic ma_vout();
        if (ma_pos.size() == 0) return 1'b0;
        return ma_pos[0] == D - 1;
    endfunction

    task automatic ma_step(input logic dv, input logic dr, input logic fl, input logic [7:0] din);
        bitq_t a;
        logic  rdy;
        a   = ma_adv(dr);
        rdy = ma_ready(dr);
        for (int k = 0; k < a.size(); k++) begin
            if (a[k]) begin
                ma_pos[k] = ma_pos[k] + 1;
                if (ma_pos[k] == D - 1 && !fl) ma_last = ma_data[k];
            end
        end
        if (ma_pos.size() > 0) begin
            if (ma_pos[0] == D) begin
                void'(ma_pos.pop_front());
                void'(ma_data.pop_front());
            end
        end
        if (fl) begin
            ma_pos.delete();
            ma_data.delete();
        end else if (dv && rdy) begin
            ma_pos.push_back(0);
            ma_data.push_back(din);
        end
    endtask

    // Model B: single-slot FIFO.
    task automatic mb_step(input logic dv, input logic dr, input logic fl, input logic [15:0] din);
        logic rdy;
        rdy = (mb_q.size() == 0) || dr;
        if (mb_q.size() > 0 && dr) void'(mb_q.pop_front());
        if (fl) begin
            mb_q.delete();
        end else if (dv && rdy) begin
            mb_q.push_back(din);
            mb_last = din;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            ma_pos.delete();
            ma_data.delete();
            ma_last = A_RST;
            mb_q.delete();
            mb_last = B_RST;
        end else begin
            ma_step(a_din_valid, a_dout_ready, a_flush, a_din);
            mb_step(b_din_valid, b_dout_ready, b_flush, b_din);
        end
    end

    initial forever begin
        @(negedge clk);
        chk("a_dout_valid", 32'(a_dout_valid), 32'(ma_vout()));
        chk("a_dout",       32'(a_dout),       32'(ma_last));
        chk("a_din_ready",  32'(a_din_ready),  32'(ma_ready(a_dout_ready)));
        chk("a_occupancy",  32'(a_occupancy),  32'(ma_pos.size()));
        chk("b_dout_valid", 32'(b_dout_valid), 32'(mb_q.size() > 0));
        chk("b_dout",       32'(b_dout),       32'(mb_last));
        chk("b_din_ready",  32'(b_din_ready),  32'((mb_q.size() == 0) || b_dout_ready));
        chk("b_occupancy",  32'(b_occupancy),  32'(mb_q.size()));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] bp_words [4];
        bp_words[0] = 8'hA1; bp_words[1] = 8'hA2; bp_words[2] = 8'hA3; bp_words[3] = 8'hA4;

        // Power-on reset.
        #1 reset = 1'b1;
        @(posedge clk);
        step();
        chk("rst_a_valid", 32'(a_dout_valid), 32'd0);
        chk("rst_a_dout",  32'(a_dout),       32'h3C);
        chk("rst_a_occ",   32'(a_occupancy),  32'd0);
        chk("rst_b_dout",  32'(b_dout),       32'hA5A5);
        reset = 1'b0;
        #1;
        chk("rst_a_ready", 32'(a_din_ready), 32'd1);
        chk("rst_b_ready", 32'(b_din_ready), 32'd1);

        // Streaming 0x01..0x10 with the consumer always ready.
        a_dout_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            a_din_valid = (c < 16);
            a_din       = 8'(c + 1);
            step();
            chk("stream_valid", 32'(a_dout_valid), 32'((c >= 3) && (c < 19)));
            if (c >= 3 && c < 19) chk("stream_data", 32'(a_dout), 32'(c - 2));
        end
        a_din_valid = 1'b0;

        // Backpressure with bubbles: A1, idle, A2, idle, A3 into a stalled output.
        a_dout_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a_din_valid = (k % 2 == 0);
            a_din       = bp_words[k / 2];
            step();
        end
        a_din_valid = 1'b0;
        repeat (4) step();
        chk("bp_occ3",   32'(a_occupancy),  32'd3);
        chk("bp_valid",  32'(a_dout_valid), 32'd1);
        chk("bp_head",   32'(a_dout),       32'hA1);
        chk("bp_ready",  32'(a_din_ready),  32'd1);
        a_din_valid = 1'b1;
        a_din       = 8'hA4;
        step();
        a_din_valid = 1'b0;
        chk("full_occ4",  32'(a_occupancy), 32'd4);
        chk("full_ready", 32'(a_din_ready), 32'd0);

        // Full pipe with simultaneous input and output: whole pipe shifts.
        a_dout_ready = 1'b1;
        a_din_valid  = 1'b1;
        a_din        = 8'h55;
        #1;
        chk("pass_ready", 32'(a_din_ready), 32'd1);
        step();
        a_din_valid = 1'b0;
        chk("pass_occ4", 32'(a_occupancy), 32'd4);
        chk("drain_0",   32'(a_dout),      32'hA2);
        step();
        chk("drain_1",   32'(a_dout),      32'hA3);
        chk("drain_occ", 32'(a_occupancy), 32'd3);
        step();
        chk("drain_2",   32'(a_dout),      32'hA4);
        step();
        chk("pass_55",   32'(a_dout),       32'h55);
        chk("pass_55v",  32'(a_dout_valid), 32'd1);
        step();
        chk("empty_valid", 32'(a_dout_valid), 32'd0);
        chk("empty_occ",   32'(a_occupancy),  32'd0);

        // Flush with an input offered in the same cycle.
        a_dout_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_din_valid = 1'b1;
            a_din       = 8'(8'hC1 + k);
            step();
        end
        a_flush     = 1'b1;
        a_din_valid = 1'b1;
        a_din       = 8'hEE;
        #1;
        chk("flush_ready", 32'(a_din_ready), 32'd1);
        step();
        a_flush     = 1'b0;
        a_din_valid = 1'b0;
        chk("flush_occ",   32'(a_occupancy),  32'd0);
        chk("flush_valid", 32'(a_dout_valid), 32'd0);
        chk("flush_hold",  32'(a_dout),       32'h55);
        a_dout_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("flush_no_ee", 32'(a_dout_valid), 32'd0);
        end

        // Single-stage build: one-cycle fall-through and 1 word/cycle.
        b_dout_ready = 1'b0;
        b_din_valid  = 1'b1;
        b_din        = 16'hBEEF;
        step();
        b_din_valid = 1'b0;
        chk("b_beef_valid", 32'(b_dout_valid), 32'd1);
        chk("b_beef",       32'(b_dout),       32'hBEEF);
        chk("b_full_ready", 32'(b_din_ready),  32'd0);
        b_dout_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            b_din_valid = 1'b1;
            b_din       = 16'(16'h1000 + k);
            #1;
            chk("b_sus_ready", 32'(b_din_ready), 32'd1);
            step();
            chk("b_sus_data",  32'(b_dout),      32'(16'h1000 + k));
            chk("b_sus_occ",   32'(b_occupancy), 32'd1);
        end
        b_din_valid = 1'b0;
        step();
        chk("b_idle_valid", 32'(b_dout_valid), 32'd0);
        chk("b_idle_hold",  32'(b_dout),       32'h1007);

        // Random traffic on both instances, alternating light and heavy backpressure.
        for (int c = 0; c < 1500; c++) begin
            int unsigned thr;
            thr          = ((c / 200) % 2 == 1) ? 8 : 3;
            a_din_valid  = ($urandom_range(0, 3) != 0);
            a_din        = 8'($urandom);
            a_dout_ready = ($urandom_range(0, 9) < thr);
            a_flush      = ($urandom_range(0, 47) == 0);
            b_din_valid  = ($urandom_range(0, 2) != 0);
            b_din        = 16'($urandom);
            b_dout_ready = ($urandom_range(0, 9) < thr);
            b_flush      = ($urandom_range(0, 47) == 0);
            step();
        end

        // Reset mid-stream with three words in flight.
        a_flush = 1'b1; b_flush = 1'b1;
        a_din_valid = 1'b0; b_din_valid = 1'b0;
        a_dout_ready = 1'b0; b_dout_ready = 1'b0;
        step();
        a_flush = 1'b0; b_flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_din_valid = 1'b1;
            a_din       = 8'(8'h70 + k);
            step();
        end
        a_din_valid = 1'b0;
        chk("mid_occ3", 32'(a_occupancy), 32'd3);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(a_dout_valid), 32'd0);
        chk("mid_rst_dout",  32'(a_dout),       32'h3C);
        chk("mid_rst_occ",   32'(a_occupancy),  32'd0);
        step();
        chk("mid_rst_occ2",  32'(a_occupancy),  32'd0);
        reset = 1'b0;
        #1;
        chk("mid_rel_ready", 32'(a_din_ready), 32'd1);
        a_dout_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("mid_no_word", 32'(a_dout_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
- Parametrised successor to the single D flip-flop: a DEPTH-stage, WIDTH-bit register pipeline with a valid/ready handshake at both ends.
- Each stage stalls independently under backpressure. Empty stages (bubbles) are collapsed, so a downstream stall never drops data.
- Provides a synchronous flush and an occupancy count.
- Sits between a producer and a consumer wherever a retimed, backpressure-aware delay line is needed.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 4, number of register stages (>=1; DEPTH=0 is illegal and triggers an elaboration-time $error).
- RESET_VAL, '0, value loaded into every stage data register on reset.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all stage valids.
- din_valid  input  1  producer has data on din.
- din_ready  output  1  pipeline accepts din this cycle.
- din  input  WIDTH  input data.
- dout_valid  output  1  last stage holds valid data.
- dout_ready  input  1  consumer accepts dout this cycle.
- dout  output  WIDTH  last stage data.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Per-stage state: v[i] (valid) and d[i] (data). Stage 0 is the input stage; stage DEPTH-1 drives dout/dout_valid.
- Reset, asserted asynchronously:
  - all v[i]=0, all d[i]=RESET_VAL.
  - dout=RESET_VAL, dout_valid=0, occupancy=0.
  - din_ready=1 as soon as reset deasserts (it is combinational from v).
- Stage advance:
  - adv[DEPTH-1] = v[DEPTH-1] & dout_ready.
  - For i<DEPTH-1: adv[i] = v[i] & (!v[i+1] | adv[i+1]).
  - Stage i+1 loads d[i] and sets v[i+1]=1 when adv[i].
  - Otherwise v[i+1] clears if adv[i+1], else it holds.
- Input:
  - din_ready = !v[0] | adv[0], combinational with no register in the ready path.
  - A transfer occurs when din_valid & din_ready: d[0]<=din, v[0]<=1.
  - If there is no transfer and adv[0], v[0]<=0.
- Data hold: d[i] updates only when a valid transfer enters stage i. It is never overwritten by a bubble. dout shows the last loaded value even while dout_valid=0.
- Latency: with no stalls, a word accepted at edge N appears with dout_valid=1 after edge N+DEPTH-1. Minimum fall-through is DEPTH-1 cycles after acceptance, i.e. DEPTH register stages.
- Throughput: 1 word/cycle sustained while dout_ready=1.
- Full: all v=1 and dout_ready=0 gives din_ready=0. With all v=1 and dout_ready=1, din_ready=1 and the whole pipe shifts.
- Bubble collapse: when the output is stalled, upstream valid stages advance into empty downstream stages until they are packed.
- Flush:
  - On an edge with flush=1, all v[i]<=0.
  - An input transfer in the same cycle is discarded. din_ready is still computed normally, but the accepted word is dropped.
  - d[i] holds.
  - The output handshake in a flush cycle completes normally if dout_valid & dout_ready.
- Reset mid-operation discards all contents immediately. No partial word is ever presented afterwards.
- occupancy: registered popcount of v, updated on the same edge as v, range 0..DEPTH.
- Invariant: v never changes except by the rules above. Data order is strictly FIFO, with no reordering or duplication.

Decomposition:
- Package dff_pipe_pkg: occupancy-width helper function occ_w(depth)=$clog2(depth+1).
- Sub-module dff_pipe_stage: one stage with WIDTH/RESET_VAL parameters.
  - Ports: clk, reset, flush, up_valid, up_data, dn_adv, v, d, adv.
  - Instantiated DEPTH times via generate; the top level handles only the ends and occupancy.

Test Plan:
- Reset check: reset=1 mid-stream with 3 words in flight -> v all 0, dout=RESET_VAL, dout_valid=0, occupancy=0 while reset is high. After release, din_ready=1.
- Streaming, DEPTH=4, WIDTH=8: dout_ready=1, send 0x01..0x10 back-to-back -> first dout_valid is 3 cycles after the first acceptance. Output is 0x01..0x10 in order, one per cycle, with no gaps.
- Backpressure and bubble collapse:
  - Send 0xA1, idle, 0xA2, idle, 0xA3 with dout_ready=0 -> after settling, occupancy=3 and stages are packed at the output end.
  - Send 0xA4 -> occupancy=4, din_ready=0.
  - Then dout_ready=1 -> output is A1,A2,A3,A4.
- Full-pipe pass-through: pipe full, dout_ready=1 and din_valid=1 (0x55) in the same cycle -> din_ready=1, occupancy stays 4, and 0x55 exits 4 cycles later.
- Flush: 3 words in flight, flush=1 with din_valid=1 (0xEE) and dout_ready=0 in the same cycle -> next cycle occupancy=0 and dout_valid=0. 0xEE never appears on dout.
- DEPTH=1, WIDTH=16 build: single word 0xBEEF -> dout_valid the cycle after acceptance. Simultaneous in/out each cycle sustains 1 word/cycle.
